// File: rtl/inst_mem_pkg.sv
// Shared types, constants and the fetch-address legality helper for the
// instruction-memory responder.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } inst_mem_state_t;

  localparam logic [31:0] INST_MEM_ZERO_WORD = 32'h0;

  // A fetch is legal when it is word aligned and lands inside the image window.
  function automatic logic fetch_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] num_words);
    return (addr[1:0] == 2'b00) &&
           (addr >= base) &&
           (((addr - base) >> 2) < num_words);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Program-image storage: one synchronous write port, one combinational read
// port so fetches are answered in the same cycle.
module inst_mem_array #(
  parameter int unsigned p_num_words = 256
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(p_num_words)-1:0] wr_addr,
  input  logic [31:0]                    wr_data,
  input  logic [$clog2(p_num_words)-1:0] rd_addr,
  output logic [31:0]                    rd_data
);

  logic [31:0] mem [p_num_words];

  // NOTE: storage is deliberately not reset; a reset would turn the array into
  // flops with a huge reset fan-out, and stale words are allowed to survive.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_mem.sv
// Instruction-memory responder: streaming image load under an IDLE/LOAD/RUN
// FSM, zero-latency fetch port, sticky bad-fetch flag and fetch counter.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned p_num_words = 256,
  parameter logic [31:0] p_base_addr = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        load_start,
  input  logic [31:0] load_len,
  input  logic        load_val,
  output logic        load_rdy,
  input  logic [31:0] load_data,
  output logic        running,
  output logic        err,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(p_num_words);
  localparam int unsigned LW = AW + 1;

  inst_mem_state_t state;
  logic [AW-1:0]   wptr;
  logic [LW-1:0]   len;
  logic [LW-1:0]   start_len;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_data;
  logic            legal;
  logic            wr_en;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    start_len = LW'(load_len);
    if (load_len >= 32'(p_num_words)) start_len = LW'(p_num_words);
  end

  assign legal  = fetch_legal(imemreq_addr, p_base_addr, 32'(p_num_words));
  assign rd_idx = AW'((imemreq_addr - p_base_addr) >> 2);
  assign wr_en  = (state == LOAD) && load_val;

  inst_mem_array #(.p_num_words(p_num_words)) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (load_data),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  assign load_rdy = (state == LOAD);
  assign running  = (state == RUN);

  // The processor cannot stall on imem, so the response is purely combinational.
  assign imemresp_data = (running && imemreq_val && legal) ? rd_data : INST_MEM_ZERO_WORD;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wptr        <= '0;
      len         <= '0;
      err         <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            wptr  <= '0;
            len   <= start_len;
            state <= (start_len == '0) ? RUN : LOAD;
          end
        end
        LOAD: begin
          if (load_val) begin
            wptr <= wptr + AW'(1);
            if ({1'b0, wptr} == len - LW'(1)) state <= RUN;
          end
        end
        RUN: begin
          // Reprogramming wins over a fetch on the same edge.
          if (load_start) begin
            err         <= 1'b0;
            fetch_count <= '0;
            wptr        <= '0;
            len         <= start_len;
            state       <= (start_len == '0) ? RUN : LOAD;
          end else if (imemreq_val) begin
            fetch_count <= fetch_count + 32'd1;
            if (!legal) err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Randomized scoreboard bench for inst_mem against a behavioural image model.
module tb_inst_mem;

  localparam int unsigned NW   = 256;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemreq_val = 1'b0;
  logic [31:0] imemreq_addr = '0;
  logic [31:0] imemresp_data;
  logic        load_start = 1'b0;
  logic [31:0] load_len = '0;
  logic        load_val = 1'b0;
  logic        load_rdy;
  logic [31:0] load_data = '0;
  logic        running;
  logic        err;
  logic [31:0] fetch_count;

  inst_mem #(.p_num_words(NW), .p_base_addr(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_addr  (imemreq_addr),
    .imemresp_data (imemresp_data),
    .load_start    (load_start),
    .load_len      (load_len),
    .load_val      (load_val),
    .load_rdy      (load_rdy),
    .load_data     (load_data),
    .running       (running),
    .err           (err),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: image contents plus loading/running/err/count bookkeeping.
  logic [31:0] m_mem [NW];
  bit          m_loading = 0;
  bit          m_running = 0;
  bit          m_err     = 0;
  logic [31:0] m_count   = '0;
  int unsigned m_len     = 0;
  int unsigned m_wptr    = 0;

  function automatic bit m_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && ((a - BASE) / 4 < NW);
  endfunction

  function automatic logic [31:0] m_resp();
    if (m_running && imemreq_val && m_legal(imemreq_addr))
      return m_mem[int'((imemreq_addr - BASE) / 4)];
    return 32'h0;
  endfunction

  task automatic m_update();
    if (rst) begin
      m_loading = 0; m_running = 0; m_err = 0; m_count = '0;
    end else if (m_loading) begin
      if (load_val) begin
        m_mem[m_wptr] = load_data;
        m_wptr++;
        if (m_wptr == m_len) begin
          m_loading = 0;
          m_running = 1;
        end
      end
    end else if (load_start) begin
      m_len  = (load_len > NW) ? NW : int'(load_len);
      m_wptr = 0;
      m_err  = 0;
      m_count = '0;
      m_loading = (m_len != 0);
      m_running = (m_len == 0);
    end else if (m_running && imemreq_val) begin
      m_count = m_count + 1;
      if (!m_legal(imemreq_addr)) m_err = 1;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: the response is combinational, so each cycle's expectation is
  // compared at the falling edge of that cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("fetch_data@%08h", e.addr), imemresp_data, e.data);
      end
    end
  end

  task automatic check_state();
    check("running", {31'b0, running}, {31'b0, m_running});
    check("load_rdy", {31'b0, load_rdy}, {31'b0, m_loading});
    check("err", {31'b0, err}, {31'b0, m_err});
    check("fetch_count", fetch_count, m_count);
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic tick();
    exp_t e;
    e.addr = imemreq_addr;
    e.data = m_resp();
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    m_update();
    #1;
    check_state();
  endtask

  logic [31:0] img[$];

  task automatic load_image(input logic [31:0] len, input int drop_at,
                            input int gap_pct, input int stray_pct);
    int k;
    k = 0;
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    for (int guard = 0; guard < 4000 && m_loading; guard++) begin
      if (k == drop_at) begin
        load_val = 1'b0;
        tick();
        tick();
        drop_at = -1;
      end
      load_val   = ($urandom_range(0, 99) >= gap_pct);
      load_data  = (k < img.size()) ? img[k] : $urandom;
      load_start = ($urandom_range(0, 99) < stray_pct);
      load_len   = $urandom_range(0, 8);
      tick();
      if (load_val) k++;
    end
    load_val   = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    imemreq_val  = 1'b1;
    imemreq_addr = a;
    tick();
    imemreq_val  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return BASE + 4 * $urandom_range(0, NW - 1);
      1:       return (BASE + 4 * $urandom_range(0, NW - 1)) | 32'($urandom_range(1, 3));
      2:       return BASE + 4 * NW + 4 * $urandom_range(0, 1000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) m_mem[i] = '0;

    // Reset, then an ignored fetch.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fetch(32'h0);
    fetch(32'h4);

    // Oversized image: clamped to NW handshakes; stray load_start is ignored.
    img.delete();
    load_image(32'd1000, -1, 25, 5);
    for (int i = 0; i < 20; i++) fetch(BASE + 4 * $urandom_range(0, NW - 1));

    // Three-word program with a two-cycle load_val drop after the first word.
    img.delete();
    img.push_back(32'h00500093);
    img.push_back(32'h00108113);
    img.push_back(32'h00000013);
    load_image(32'd3, 1, 0, 0);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);

    // Illegal fetches set the sticky flag; reprogramming with length 0 clears it.
    fetch(32'h2);
    fetch(32'h400);
    fetch(32'h4);
    tick();
    img.delete();
    load_image(32'd0, -1, 0, 0);
    fetch(32'h8);

    // Reset mid-load, then reset colliding with load_start.
    load_start = 1'b1;
    load_len   = 32'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_val  = 1'b1;
      load_data = $urandom;
      tick();
    end
    load_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_start = 1'b1;
    load_len = 32'd5;
    tick();
    rst = 1'b0;
    load_start = 1'b0;
    tick();

    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    load_image(32'd4, -1, 0, 0);
    for (int i = 0; i < 5; i++) fetch(BASE + 4 * i);

    // Randomized traffic with occasional reprogramming.
    for (int n = 0; n < 300; n++) begin
      if (n % 100 == 99) begin
        img.delete();
        load_image(32'($urandom_range(0, 20)), -1, 30, 0);
      end
      imemreq_val  = ($urandom_range(0, 99) < 80);
      imemreq_addr = rand_addr();
      tick();
    end
    imemreq_val = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
